alu_reg_file: RTL and testbench
===============================

ALU_REG_FILE -- requirements
Module: alu_reg_file

Interface
REQ-001 The block SHALL have no parameters; data width is fixed at 32 bits and register address width at 5 bits.
REQ-002 clk  in  1  clock; all state updates occur on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 addr_a  in  5  read port A register index (rs).
REQ-005 addr_b  in  5  read port B register index (rt).
REQ-006 write_addr  in  5  write port register index (rd).
REQ-007 write  in  1  write enable for the write port.
REQ-008 data_in  in  32  write data.
REQ-009 fncode  in  6  ALU function select (MIPS R-type funct field).
REQ-010 shamt  in  5  shift amount for immediate shifts.
REQ-011 a  out  32  contents of register addr_a.
REQ-012 b  out  32  contents of register addr_b.
REQ-013 r  out  32  ALU result, computed from a and b.
REQ-014 register_v0  out  32  current contents of register 2 ($v0).

Function
REQ-015 The register file SHALL hold 32 registers of 32 bits each.
REQ-016 Reads SHALL be combinational; a and b follow addr_a and addr_b in the same cycle.
REQ-017 Register 0 SHALL always read 0, and writes to it SHALL be discarded.
REQ-018 When write=1 at a rising clk edge and write_addr!=0, data_in SHALL be stored in register write_addr.
REQ-019 There SHALL be no write-to-read bypass: a read of the register being written returns the old value until after the edge.
REQ-020 register_v0 SHALL reflect register 2 combinationally from stored state, updating the cycle after a write to register 2.
REQ-021 The ALU SHALL be purely combinational, with r a function of a, b, shamt and fncode only.
REQ-022 ALU function codes:
- ADDU 0x21: r = a+b, modulo 2^32, no overflow trap.
- SUBU 0x23: r = a-b, modulo 2^32.
- AND 0x24, OR 0x25, XOR 0x26, NOR 0x27: bitwise operations.
- SLT 0x2A: r = 1 if a<b as signed, else 0.
- SLTU 0x2B: r = 1 if a<b as unsigned, else 0.
- JR 0x08: r = a (pass-through).
REQ-023 Shift function codes (see REQ-027):
- SLL 0x00, SRL 0x02, SRA 0x03: b shifted by shamt.
- SLLV 0x04, SRLV 0x06, SRAV 0x07: b shifted by a[4:0].
- SRA and SRAV replicate b[31].
REQ-024 Any undefined fncode SHALL produce r = 0.
REQ-025 A write and a read of the same address in the same cycle SHALL be handled per REQ-019 with no hazard signalling.

Reset
REQ-026 On a rising clk edge with reset=1:
- All 32 registers SHALL clear to 0, so a, b, register_v0 and therefore r (for ADDU) read 0 the following cycle.
- reset SHALL take priority over a simultaneous write.
- Reset asserted mid-operation SHALL discard the pending write.

Configuration
REQ-027 Macro ALU_SHIFT_EN SHALL control the shift operations.
- Defined: the six shift codes of REQ-023 are implemented.
- Undefined: those codes SHALL produce r = 0, exactly like undefined codes.

Structure
REQ-028 A shared package SHALL hold the funct enum (all codes above), data and address widths, and the constant REG_V0=2.
REQ-029 The register array SHALL be one sub-module, gpr_array, providing storage, reset and $0 handling; the ALU SHALL be inline combinational logic in alu_reg_file.

Verification
REQ-030 Reset, then read addresses 0..31 -> every a, b and register_v0 read 0.
REQ-031 Write 0x0000_0005 to reg 3 and 0xFFFF_FFFF to reg 4, then ADDU with addr_a=3, addr_b=4 -> r=0x0000_0004.
REQ-032 Write 0xDEAD_BEEF to reg 0 -> a with addr_a=0 reads 0; write 0x1234 to reg 2 -> register_v0=0x1234 the next cycle, and it reads 0 in the write cycle.
REQ-033 a=0x8000_0000, b=1:
- SLT -> r=1; SLTU -> r=0; SUBU -> r=0x7FFF_FFFF; JR -> r=0x8000_0000.
- fncode 0x3F -> r=0.
REQ-034 With ALU_SHIFT_EN defined, b=0x8000_0000, shamt=4:
- SRA -> r=0xF800_0000; SRL -> r=0x0800_0000.
- Without the macro, both -> r=0.
REQ-035 Assert write=1, write_addr=5, data_in=7 in the same cycle as reset=1 -> reg 5 reads 0 afterwards.

Source files
------------

// File: rtl/alu_reg_file_pkg.sv
// Shared definitions for the register-file / ALU slice: data and address
// widths, the MIPS R-type funct codes and the index of $v0.
package alu_reg_file_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;
  localparam logic [ADDR_W-1:0] REG_V0 = 5'd2;

  typedef enum logic [5:0] {
    FN_SLL  = 6'h00,
    FN_SRL  = 6'h02,
    FN_SRA  = 6'h03,
    FN_SLLV = 6'h04,
    FN_SRLV = 6'h06,
    FN_SRAV = 6'h07,
    FN_JR   = 6'h08,
    FN_ADDU = 6'h21,
    FN_SUBU = 6'h23,
    FN_AND  = 6'h24,
    FN_OR   = 6'h25,
    FN_XOR  = 6'h26,
    FN_NOR  = 6'h27,
    FN_SLT  = 6'h2A,
    FN_SLTU = 6'h2B
  } funct_e;

endpackage

// File: rtl/alu_reg_file_gpr_array.sv
// gpr_array: 32 x 32-bit general purpose registers with two combinational
// read ports, one synchronous write port and a dedicated $v0 tap.
// $0 is hard-wired to zero on read and never written. There is no
// write-to-read bypass: a read of the register being written returns the
// stored (old) value until the clock edge.
module gpr_array
  import alu_reg_file_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic              write,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] a,
  output logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] reg_v0
);

  logic [DATA_W-1:0] regs [NUM_REGS];

  // Storage update: reset clears everything and wins over a pending write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (write && (write_addr != '0)) begin
      regs[write_addr] <= data_in;
    end
  end

  assign a      = (addr_a == '0) ? '0 : regs[addr_a];
  assign b      = (addr_b == '0) ? '0 : regs[addr_b];
  assign reg_v0 = regs[REG_V0];

endmodule

// File: rtl/alu_reg_file.sv
// alu_reg_file: register file (gpr_array) feeding a combinational MIPS
// R-type ALU. r is a pure function of a, b, shamt and fncode.
// Build option: define ALU_SHIFT_EN to implement the six shift codes;
// without it those codes return 0 like any undefined funct.
module alu_reg_file
  import alu_reg_file_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  addr_a,
  input  logic [4:0]  addr_b,
  input  logic [4:0]  write_addr,
  input  logic        write,
  input  logic [31:0] data_in,
  input  logic [5:0]  fncode,
  input  logic [4:0]  shamt,
  output logic [31:0] a,
  output logic [31:0] b,
  output logic [31:0] r,
  output logic [31:0] register_v0
);

  gpr_array u_gpr (
    .clk        (clk),
    .reset      (reset),
    .addr_a     (addr_a),
    .addr_b     (addr_b),
    .write_addr (write_addr),
    .write      (write),
    .data_in    (data_in),
    .a          (a),
    .b          (b),
    .reg_v0     (register_v0)
  );

`ifndef ALU_SHIFT_EN
  // Shift amount only feeds the shifter, which is absent in this build.
  logic unused_shamt;
  assign unused_shamt = ^shamt;
`endif

  // ALU result select; unknown functs fall through to zero.
  always_comb begin
    r = '0;
    case (fncode)
      FN_ADDU: r = a + b;
      FN_SUBU: r = a - b;
      FN_AND:  r = a & b;
      FN_OR:   r = a | b;
      FN_XOR:  r = a ^ b;
      FN_NOR:  r = ~(a | b);
      FN_SLT:  r = {31'b0, ($signed(a) < $signed(b))};
      FN_SLTU: r = {31'b0, (a < b)};
      FN_JR:   r = a;
`ifdef ALU_SHIFT_EN
      FN_SLL:  r = b << shamt;
      FN_SRL:  r = b >> shamt;
      FN_SRA:  r = $unsigned($signed(b) >>> shamt);
      FN_SLLV: r = b << a[4:0];
      FN_SRLV: r = b >> a[4:0];
      FN_SRAV: r = $unsigned($signed(b) >>> a[4:0]);
`endif
      default: r = '0;
    endcase
  end

endmodule

// File: tb/tb_alu_reg_file.sv
// Self-checking bench for alu_reg_file. A behavioural model (register
// array plus an arithmetic ALU function) predicts a, b, r and register_v0.
// Inputs change just after the falling edge and outputs are sampled 1 ns
// later, well before the next rising edge.
module tb_alu_reg_file;

  logic        clk;
  logic        reset;
  logic [4:0]  addr_a;
  logic [4:0]  addr_b;
  logic [4:0]  write_addr;
  logic        write;
  logic [31:0] data_in;
  logic [5:0]  fncode;
  logic [4:0]  shamt;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] r;
  logic [31:0] register_v0;

  int checks = 0;
  int errors = 0;

  logic [31:0] model_regs [32];
  logic [31:0] exp_q [$];

`ifdef ALU_SHIFT_EN
  localparam bit SHIFT_EN = 1'b1;
`else
  localparam bit SHIFT_EN = 1'b0;
`endif

  alu_reg_file dut (
    .clk         (clk),
    .reset       (reset),
    .addr_a      (addr_a),
    .addr_b      (addr_b),
    .write_addr  (write_addr),
    .write       (write),
    .data_in     (data_in),
    .fncode      (fncode),
    .shamt       (shamt),
    .a           (a),
    .b           (b),
    .r           (r),
    .register_v0 (register_v0)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic void model_reset();
    for (int i = 0; i < 32; i++) model_regs[i] = 32'h0;
  endfunction

  function automatic void model_write(input logic [4:0] wa, input logic [31:0] wd);
    if (wa != 5'd0) model_regs[wa] = wd;
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] ra);
    return (ra == 5'd0) ? 32'h0 : model_regs[ra];
  endfunction

  // Arithmetic right shift built from logical shifts of the complement.
  function automatic logic [31:0] sra_ref(input logic [31:0] v, input int amt);
    return v[31] ? ~((~v) >> amt) : (v >> amt);
  endfunction

  function automatic logic [31:0] ref_alu(input logic [5:0] fn, input logic [31:0] x,
                                          input logic [31:0] y, input logic [4:0] sh);
    logic [31:0] res;
    int amt_i, amt_v;
    amt_i = int'(sh);
    amt_v = int'(x[4:0]);
    res = 32'h0;
    case (fn)
      6'h21: res = x + y;
      6'h23: res = x - y;
      6'h24: res = x & y;
      6'h25: res = x | y;
      6'h26: res = x ^ y;
      6'h27: res = ~(x | y);
      6'h2A: res = ((x ^ 32'h8000_0000) < (y ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
      6'h2B: res = (x < y) ? 32'd1 : 32'd0;
      6'h08: res = x;
      6'h00: res = SHIFT_EN ? (y << amt_i) : 32'h0;
      6'h02: res = SHIFT_EN ? (y >> amt_i) : 32'h0;
      6'h03: res = SHIFT_EN ? sra_ref(y, amt_i) : 32'h0;
      6'h04: res = SHIFT_EN ? (y << amt_v) : 32'h0;
      6'h06: res = SHIFT_EN ? (y >> amt_v) : 32'h0;
      6'h07: res = SHIFT_EN ? sra_ref(y, amt_v) : 32'h0;
      default: res = 32'h0;
    endcase
    return res;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_write(input logic [4:0] wa, input logic [31:0] wd);
    @(negedge clk);
    write      = 1'b1;
    write_addr = wa;
    data_in    = wd;
    @(posedge clk);
    #1;
    write = 1'b0;
    model_write(wa, wd);
  endtask

  task automatic drive_reset(input int cycles);
    @(negedge clk);
    reset = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic drive_read(input logic [4:0] ra, input logic [4:0] rb,
                            input logic [5:0] fn, input logic [4:0] sh);
    @(negedge clk);
    addr_a = ra;
    addr_b = rb;
    fncode = fn;
    shamt  = sh;
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    drive_reset(2);
    for (int i = 0; i < 32; i++) begin
      drive_read(5'(i), 5'(31 - i), 6'h21, 5'd0);
      checks++;
      if (a !== 32'h0) begin errors++; $display("FAIL reset_a addr=%0d got=%h exp=%h", i, a, 32'h0); end
      checks++;
      if (b !== 32'h0) begin errors++; $display("FAIL reset_b addr=%0d got=%h exp=%h", 31 - i, b, 32'h0); end
      checks++;
      if (register_v0 !== 32'h0) begin errors++; $display("FAIL reset_v0 got=%h exp=%h", register_v0, 32'h0); end
      checks++;
      if (r !== 32'h0) begin errors++; $display("FAIL reset_r got=%h exp=%h", r, 32'h0); end
    end
  endtask

  task automatic test_addu();
    drive_write(5'd3, 32'h0000_0005);
    drive_write(5'd4, 32'hFFFF_FFFF);
    drive_read(5'd3, 5'd4, 6'h21, 5'd0);
    checks++;
    if (r !== 32'h0000_0004) begin errors++; $display("FAIL addu_wrap got=%h exp=%h", r, 32'h0000_0004); end
  endtask

  task automatic test_zero_reg_and_v0();
    logic [31:0] v0_old;
    drive_write(5'd0, 32'hDEAD_BEEF);
    drive_read(5'd0, 5'd0, 6'h21, 5'd0);
    checks++;
    if (a !== 32'h0) begin errors++; $display("FAIL reg0_write_discarded got=%h exp=%h", a, 32'h0); end
    // $v0 must still show the old value during the write cycle.
    v0_old = model_regs[2];
    @(negedge clk);
    write = 1'b1; write_addr = 5'd2; data_in = 32'h0000_1234; addr_a = 5'd2;
    #1;
    checks++;
    if (register_v0 !== v0_old) begin errors++; $display("FAIL v0_write_cycle got=%h exp=%h", register_v0, v0_old); end
    checks++;
    if (a !== v0_old) begin errors++; $display("FAIL no_bypass_a got=%h exp=%h", a, v0_old); end
    @(posedge clk);
    #1;
    write = 1'b0;
    model_write(5'd2, 32'h0000_1234);
    checks++;
    if (register_v0 !== 32'h0000_1234) begin errors++; $display("FAIL v0_after_write got=%h exp=%h", register_v0, 32'h0000_1234); end
  endtask

  task automatic test_alu_corners();
    logic [5:0]  fns  [5];
    logic [31:0] want [5];
    fns  = '{6'h2A, 6'h2B, 6'h23, 6'h08, 6'h3F};
    want = '{32'h1, 32'h0, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0};
    drive_write(5'd6, 32'h8000_0000);
    drive_write(5'd7, 32'h0000_0001);
    for (int i = 0; i < 5; i++) begin
      drive_read(5'd6, 5'd7, fns[i], 5'd0);
      checks++;
      if (r !== want[i]) begin errors++; $display("FAIL alu_corner fn=%h got=%h exp=%h", fns[i], r, want[i]); end
    end
  endtask

  task automatic test_shift();
    logic [31:0] exp_sra, exp_srl;
    exp_sra = SHIFT_EN ? 32'hF800_0000 : 32'h0;
    exp_srl = SHIFT_EN ? 32'h0800_0000 : 32'h0;
    drive_write(5'd8, 32'h8000_0000);
    drive_read(5'd0, 5'd8, 6'h03, 5'd4);
    checks++;
    if (r !== exp_sra) begin errors++; $display("FAIL shift_sra got=%h exp=%h", r, exp_sra); end
    drive_read(5'd0, 5'd8, 6'h02, 5'd4);
    checks++;
    if (r !== exp_srl) begin errors++; $display("FAIL shift_srl got=%h exp=%h", r, exp_srl); end
  endtask

  task automatic test_reset_priority();
    drive_write(5'd5, 32'h0000_0099);
    @(negedge clk);
    reset = 1'b1; write = 1'b1; write_addr = 5'd5; data_in = 32'h0000_0007;
    @(posedge clk);
    #1;
    reset = 1'b0; write = 1'b0;
    model_reset();
    drive_read(5'd5, 5'd5, 6'h21, 5'd0);
    checks++;
    if (a !== 32'h0) begin errors++; $display("FAIL reset_over_write got=%h exp=%h", a, 32'h0); end
  endtask

  task automatic test_back_to_back();
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [31:0] old;
    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      wa = 5'($urandom_range(0, 31));
      wd = $urandom;
      write = 1'b1; write_addr = wa; data_in = wd; addr_a = wa;
      addr_b = 5'($urandom_range(0, 31));
      old = model_read(wa);
      #1;
      checks++;
      if (a !== old) begin errors++; $display("FAIL b2b_old_value addr=%0d got=%h exp=%h", wa, a, old); end
      @(posedge clk);
      #1;
      model_write(wa, wd);
      checks++;
      if (b !== model_read(addr_b)) begin errors++; $display("FAIL b2b_b addr=%0d got=%h exp=%h", addr_b, b, model_read(addr_b)); end
      @(negedge clk);
    end
    write = 1'b0;
  endtask

  task automatic test_random_alu();
    logic [5:0] codes [16];
    logic [5:0] fn;
    logic [4:0] ra, rb, sh;
    logic [31:0] exp_r, got;
    codes = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h21,
              6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B, 6'h01};
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 2) == 0) drive_write(5'($urandom_range(0, 31)), $urandom);
      ra = 5'($urandom_range(0, 31));
      rb = 5'($urandom_range(0, 31));
      sh = 5'($urandom_range(0, 31));
      fn = ($urandom_range(0, 4) == 0) ? 6'($urandom_range(0, 63)) : codes[$urandom_range(0, 15)];
      exp_q.push_back(ref_alu(fn, model_read(ra), model_read(rb), sh));
      drive_read(ra, rb, fn, sh);
      checks++;
      if (a !== model_read(ra)) begin errors++; $display("FAIL rand_a addr=%0d got=%h exp=%h", ra, a, model_read(ra)); end
      checks++;
      if (b !== model_read(rb)) begin errors++; $display("FAIL rand_b addr=%0d got=%h exp=%h", rb, b, model_read(rb)); end
      checks++;
      if (register_v0 !== model_regs[2]) begin errors++; $display("FAIL rand_v0 got=%h exp=%h", register_v0, model_regs[2]); end
      got   = r;
      exp_r = exp_q.pop_front();
      checks++;
      if (got !== exp_r) begin errors++; $display("FAIL rand_r fn=%h a=%h b=%h sh=%0d got=%h exp=%h", fn, a, b, sh, got, exp_r); end
    end
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    reset = 1'b1; write = 1'b0; write_addr = '0; data_in = '0;
    addr_a = '0; addr_b = '0; fncode = 6'h21; shamt = '0;
    model_reset();
    for (int i = 1; i < 8; i++) drive_write(5'(i), $urandom);
    test_reset();
    test_addu();
    test_zero_reg_and_v0();
    test_alu_corners();
    test_shift();
    test_reset_priority();
    test_back_to_back();
    test_random_alu();
    test_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
